// File: rtl/bcd_pkg.sv
// Shared types, constants and helpers for the BCD-to-decimal decoder.
// No logic of its own; no latency.
// No flow control.
package bcd_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      EMIT = 1'b1
   } state_t;

   localparam int BCD_MAX = 9;
   localparam int DEC_W   = 10;

   // Minimum binary width able to hold any n-digit decimal value (10^n - 1).
   function automatic int bcd_bin_width(input int n);
      longint v;
      int     w;
      v = 1;
      w = 0;
      for (int i = 0; i < n; i++) v = v * 10;
      for (int i = 0; i < 63; i++) if ((64'd1 << i) < v) w = i + 1;
      return w;
   endfunction

   // True for the six unused codes 10..15.
   function automatic logic digit_bad(input logic [3:0] code);
      return (code > 4'(BCD_MAX));
   endfunction

   // Binary contribution of a digit; invalid codes contribute nothing.
   function automatic logic [3:0] digit_val(input logic [3:0] code);
      return digit_bad(code) ? 4'd0 : code;
   endfunction

endpackage

// File: rtl/bcd_digit_decode.sv
// One BCD code to a one-hot decimal digit plus an invalid flag.
// Purely combinational, zero latency.
// No flow control.
module bcd_digit_decode
   import bcd_pkg::*;
(
   input  logic [3:0]       code,
   output logic [DEC_W-1:0] dec,
   output logic             invalid
);

   // Codes 10..15 produce an all-zero vector, never X.
   always_comb begin
      dec     = '0;
      invalid = digit_bad(code);
      if (!invalid) dec[code] = 1'b1;
   end

endmodule

// File: rtl/bcd_to_dec_decoder.sv
// Packed BCD word in, one one-hot decimal digit per beat out (MS digit first), running binary value.
// First beat one cycle after acceptance; N_DIGITS+1 cycles per word with out_ready high.
// Beats hold while out_ready is low; in_ready stays low until the last beat has been taken.
module bcd_to_dec_decoder
   import bcd_pkg::*;
#(
   parameter int N_DIGITS = 4,
   parameter int BIN_W    = 14,
   parameter int IDX_W    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [4*N_DIGITS-1:0] in_bcd,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DEC_W-1:0]      out_dec,
   output logic [IDX_W-1:0]      out_idx,
   output logic                  out_last,
   output logic                  out_err,
   output logic [BIN_W-1:0]      bin_value,
   output logic                  bin_err
);

   localparam int SR_W = 4 * N_DIGITS;

   state_t            state, state_nxt;
   logic [SR_W-1:0]   sr;
   logic [DEC_W-1:0]  head_dec;
   logic              head_err;
   logic [3:0]        in_head;
   logic [3:0]        sr_next;
   logic              take_in;
   logic              take_out;

   assign in_head  = in_bcd[SR_W-1 -: 4];
   assign sr_next  = sr[SR_W-5 -: 4];

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == EMIT);
   assign out_last  = out_valid && (out_idx == '0);
   assign out_dec   = out_valid ? head_dec : '0;
   assign out_err   = out_valid && head_err;

   assign take_in  = in_valid && in_ready;
   assign take_out = out_valid && out_ready;

   // The digit on display is always the top nibble of the shift register.
   bcd_digit_decode u_head (
      .code    (sr[SR_W-1 -: 4]),
      .dec     (head_dec),
      .invalid (head_err)
   );

   // Next-state: load a word in IDLE, leave EMIT once the last beat is taken.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (take_in) state_nxt = EMIT;
         EMIT:    if (take_out && out_last) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Shift register, digit index and binary accumulator; results hold in IDLE until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         sr        <= '0;
         out_idx   <= '0;
         bin_value <= '0;
         bin_err   <= 1'b0;
      end else if (take_in) begin
         sr        <= in_bcd;
         out_idx   <= IDX_W'(N_DIGITS - 1);
         bin_value <= BIN_W'(digit_val(in_head));
         bin_err   <= digit_bad(in_head);
      end else if (take_out && !out_last) begin
         sr        <= {sr[SR_W-5:0], 4'h0};
         out_idx   <= out_idx - 1'b1;
         bin_value <= bin_value * BIN_W'(10) + BIN_W'(digit_val(sr_next));
         bin_err   <= bin_err | digit_bad(sr_next);
      end
   end

endmodule
